// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI mode-0 master transmitter.
// Shared by spi_sclk_div and spi_master_tx.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} spi_state_t;

    localparam int SPI_DATA_W   = 8;
    localparam int SPI_CLK_DIV  = 4;
    localparam int SPI_CS_SETUP = 2;
    localparam int SPI_CS_HOLD  = 2;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_sclk_div.sv
// Half-period counter that generates sclk plus one-clk rise/fall strobes.
// Held cleared (sclk low) by s_rst or while enable is low.
module spi_sclk_div
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic s_rst,
    input  logic enable,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int CW = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] hp_cnt;
    logic          phase;
    logic          half_end;

    assign half_end  = (hp_cnt == HALF_LAST);
    assign rise_tick = enable && !phase && half_end;
    assign fall_tick = enable &&  phase && half_end;
    assign sclk      = phase;

    // The strobes fire on the last clk of a half period, so sclk toggles right after them.
    always_ff @(posedge clk) begin
        if (s_rst || !enable) begin
            hp_cnt <= '0;
            phase  <= 1'b0;
        end else if (half_end) begin
            hp_cnt <= '0;
            phase  <= ~phase;
        end else begin
            hp_cnt <= hp_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: shifts a latched word out MSB first with cs_n framing.
// Define SPI_MISO_CAPTURE_EN to add the miso input and the rx_data receive word.
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int DATA_W   = SPI_DATA_W,
    parameter int CLK_DIV  = SPI_CLK_DIV,
    parameter int CS_SETUP = SPI_CS_SETUP,
    parameter int CS_HOLD  = SPI_CS_HOLD
) (
    input  logic              clk,
    input  logic              s_rst,
    input  logic              start_send,
    input  logic [DATA_W-1:0] tx_data,
`ifdef SPI_MISO_CAPTURE_EN
    input  logic              miso,
    output logic [DATA_W-1:0] rx_data,
`endif
    output logic              sclk,
    output logic              mosi,
    output logic              cs_n,
    output logic              busy,
    output logic              done
);

    localparam int BW     = cnt_width(DATA_W + 1);
    localparam int DLY_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int DW     = cnt_width(DLY_MAX);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_W - 1);
    localparam logic [DW-1:0] SETUP_LAST = DW'(CS_SETUP - 1);
    localparam logic [DW-1:0] HOLD_LAST  = DW'(CS_HOLD - 1);

    spi_state_t        state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next, shifted;
    logic [BW-1:0]     bit_cnt, bit_cnt_next;
    logic [DW-1:0]     dly_cnt, dly_cnt_next;
    logic              mosi_next, cs_n_next, busy_next, done_next;
    logic              rise_tick, fall_tick;
`ifdef SPI_MISO_CAPTURE_EN
    logic [DATA_W-1:0] rx_shreg, rx_shreg_next, rx_data_next;
`endif

    assign shifted = shreg << 1;

    spi_sclk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_div (
        .clk       (clk),
        .s_rst     (s_rst),
        .enable    (state == SHIFT),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Every pin is computed one cycle ahead and registered, so outputs track the next state.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
        dly_cnt_next = dly_cnt;
        mosi_next    = mosi;
        cs_n_next    = cs_n;
        done_next    = 1'b0;
        busy_next    = 1'b0;
        case (state)
            IDLE: begin
                mosi_next = 1'b0;
                cs_n_next = 1'b1;
                if (start_send) begin
                    state_next   = SETUP;
                    shreg_next   = tx_data;
                    mosi_next    = tx_data[DATA_W-1];
                    cs_n_next    = 1'b0;
                    dly_cnt_next = '0;
                end
            end
            SETUP: begin
                if (dly_cnt == SETUP_LAST) begin
                    state_next   = SHIFT;
                    bit_cnt_next = '0;
                end else begin
                    dly_cnt_next = dly_cnt + 1'b1;
                end
            end
            SHIFT: begin
                if (fall_tick) begin
                    if (bit_cnt == BIT_LAST) begin
                        state_next   = HOLD;
                        dly_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                        shreg_next   = shifted;
                        mosi_next    = shifted[DATA_W-1];
                    end
                end
            end
            HOLD: begin
                if (dly_cnt == HOLD_LAST) begin
                    state_next = IDLE;
                    cs_n_next  = 1'b1;
                    mosi_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    dly_cnt_next = dly_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
`ifdef SPI_MISO_CAPTURE_EN
        rx_shreg_next = rx_shreg;
        rx_data_next  = rx_data;
        if (fall_tick) rx_shreg_next = DATA_W'({rx_shreg, miso});
        if (done_next) rx_data_next = rx_shreg;
`endif
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            dly_cnt <= '0;
            mosi    <= 1'b0;
            cs_n    <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SPI_MISO_CAPTURE_EN
            rx_shreg <= '0;
            rx_data  <= '0;
`endif
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            dly_cnt <= dly_cnt_next;
            mosi    <= mosi_next;
            cs_n    <= cs_n_next;
            busy    <= busy_next;
            done    <= done_next;
`ifdef SPI_MISO_CAPTURE_EN
            rx_shreg <= rx_shreg_next;
            rx_data  <= rx_data_next;
`endif
        end
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Directed self-checking bench for spi_master_tx (default and 1-bit/CLK_DIV=1 instances).
// Exercises the receive path when SPI_MISO_CAPTURE_EN is defined.
module tb_spi_master_tx;

    logic       clk = 1'b0;
    logic       s_rst = 1'b1;
    logic       start_send = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       sclk, mosi, cs_n, busy, done;
    logic       s_start = 1'b0;
    logic [0:0] s_tx = 1'b0;
    logic       s_sclk, s_mosi, s_cs_n, s_busy, s_done;
`ifdef SPI_MISO_CAPTURE_EN
    logic       miso, s_miso;
    logic [7:0] rx_data;
    logic [0:0] s_rx_data;
    assign miso   = mosi;
    assign s_miso = s_mosi;
`endif

    int checks = 0;
    int errors = 0;

    int         mon_done_cyc, mon_done_cnt, mon_rises, mon_cs_fall;
    logic [7:0] mon_bits;
    logic       mon_cs_at_done, mon_busy_at_done, mon_mosi_at_done;

    always #5 clk = ~clk;

    spi_master_tx u_dut (
        .clk        (clk),
        .s_rst      (s_rst),
        .start_send (start_send),
        .tx_data    (tx_data),
`ifdef SPI_MISO_CAPTURE_EN
        .miso       (miso),
        .rx_data    (rx_data),
`endif
        .sclk       (sclk),
        .mosi       (mosi),
        .cs_n       (cs_n),
        .busy       (busy),
        .done       (done)
    );

    spi_master_tx #(
        .DATA_W  (1),
        .CLK_DIV (1)
    ) u_small (
        .clk        (clk),
        .s_rst      (s_rst),
        .start_send (s_start),
        .tx_data    (s_tx),
`ifdef SPI_MISO_CAPTURE_EN
        .miso       (s_miso),
        .rx_data    (s_rx_data),
`endif
        .sclk       (s_sclk),
        .mosi       (s_mosi),
        .cs_n       (s_cs_n),
        .busy       (s_busy),
        .done       (s_done)
    );

    // Call just after a negedge; the accept edge follows, returns at start of cycle 1.
    task automatic start_frame(input logic [7:0] d);
        tx_data    = d;
        start_send = 1'b1;
        @(posedge clk);
        #1;
        start_send = 1'b0;
        tx_data    = ~d;
    endtask

    task automatic monitor_frame(input int max_cyc, input int pulse_a, input int pulse_b,
                                 input bit stop_at_done);
        logic prev_sclk = 1'b0;
        mon_done_cyc = -1; mon_done_cnt = 0; mon_rises = 0; mon_cs_fall = -1;
        mon_bits = 8'h00; mon_cs_at_done = 1'bx; mon_busy_at_done = 1'bx; mon_mosi_at_done = 1'bx;
        for (int c = 1; c <= max_cyc; c++) begin
            @(negedge clk);
            if (sclk && !prev_sclk) begin
                mon_rises++;
                mon_bits = {mon_bits[6:0], mosi};
            end
            prev_sclk = sclk;
            if (!cs_n && mon_cs_fall < 0) mon_cs_fall = c;
            if (done) begin
                mon_done_cnt++;
                if (mon_done_cyc < 0) begin
                    mon_done_cyc = c; mon_cs_at_done = cs_n;
                    mon_busy_at_done = busy; mon_mosi_at_done = mosi;
                end
                if (stop_at_done) break;
            end
            if (c == pulse_a || c == pulse_b) begin
                start_send = 1'b1; tx_data = 8'h00;
            end else begin
                start_send = 1'b0;
            end
        end
        start_send = 1'b0;
    endtask

    task automatic test_reset;
        s_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (sclk !== 1'b0) begin errors++; $display("[TB] FAIL rst_sclk: got %b expected 0", sclk); end
        checks++; if (mosi !== 1'b0) begin errors++; $display("[TB] FAIL rst_mosi: got %b expected 0", mosi); end
        checks++; if (cs_n !== 1'b1) begin errors++; $display("[TB] FAIL rst_cs_n: got %b expected 1", cs_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
        checks++; if (s_cs_n !== 1'b1) begin errors++; $display("[TB] FAIL rst_small_cs_n: got %b expected 1", s_cs_n); end
`ifdef SPI_MISO_CAPTURE_EN
        checks++; if (rx_data !== 8'h00) begin errors++; $display("[TB] FAIL rst_rx_data: got %h expected 00", rx_data); end
`endif
        s_rst = 1'b0;
        @(negedge clk);
        checks++; if (cs_n !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL post_rst_idle: got cs_n=%b busy=%b expected 1/0", cs_n, busy); end
    endtask

    task automatic test_basic_frame;
        start_frame(8'hA5);
        monitor_frame(80, -1, -1, 1'b0);
        checks++; if (mon_cs_fall !== 1) begin errors++; $display("[TB] FAIL a5_cs_fall: got %0d expected 1", mon_cs_fall); end
        checks++; if (mon_rises !== 8) begin errors++; $display("[TB] FAIL a5_rises: got %0d expected 8", mon_rises); end
        checks++; if (mon_bits !== 8'hA5) begin errors++; $display("[TB] FAIL a5_bits: got %h expected a5", mon_bits); end
        checks++; if (mon_done_cyc !== 69) begin errors++; $display("[TB] FAIL a5_done_cyc: got %0d expected 69", mon_done_cyc); end
        checks++; if (mon_done_cnt !== 1) begin errors++; $display("[TB] FAIL a5_done_cnt: got %0d expected 1", mon_done_cnt); end
        checks++; if (mon_cs_at_done !== 1'b1) begin errors++; $display("[TB] FAIL a5_cs_at_done: got %b expected 1", mon_cs_at_done); end
        checks++; if (mon_busy_at_done !== 1'b0) begin errors++; $display("[TB] FAIL a5_busy_at_done: got %b expected 0", mon_busy_at_done); end
        checks++; if (mon_mosi_at_done !== 1'b0) begin errors++; $display("[TB] FAIL a5_mosi_at_done: got %b expected 0", mon_mosi_at_done); end
    endtask

    task automatic test_ignore_start;
        start_frame(8'h5A);
        monitor_frame(90, 10, 40, 1'b0);
        checks++; if (mon_done_cnt !== 1) begin errors++; $display("[TB] FAIL ign_done_cnt: got %0d expected 1", mon_done_cnt); end
        checks++; if (mon_done_cyc !== 69) begin errors++; $display("[TB] FAIL ign_done_cyc: got %0d expected 69", mon_done_cyc); end
        checks++; if (mon_bits !== 8'h5A) begin errors++; $display("[TB] FAIL ign_bits: got %h expected 5a", mon_bits); end
        checks++; if (mon_rises !== 8) begin errors++; $display("[TB] FAIL ign_rises: got %0d expected 8", mon_rises); end
    endtask

    task automatic test_back_to_back;
        logic first_cs;
        start_frame(8'hA5);
        monitor_frame(80, -1, -1, 1'b1);
        first_cs = mon_cs_at_done;
        checks++; if (mon_done_cyc !== 69) begin errors++; $display("[TB] FAIL b2b_first_done: got %0d expected 69", mon_done_cyc); end
        start_frame(8'h3C);
        monitor_frame(80, -1, -1, 1'b1);
        checks++; if (first_cs !== 1'b1 || mon_cs_fall !== 1) begin errors++; $display("[TB] FAIL b2b_cs_gap: got done_cs=%b fall=%0d expected 1/1", first_cs, mon_cs_fall); end
        checks++; if (mon_bits !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_bits: got %h expected 3c", mon_bits); end
        checks++; if (mon_done_cyc !== 69) begin errors++; $display("[TB] FAIL b2b_second_done: got %0d expected 69", mon_done_cyc); end
`ifdef SPI_MISO_CAPTURE_EN
        checks++; if (rx_data !== 8'h3C) begin errors++; $display("[TB] FAIL b2b_rx_data: got %h expected 3c", rx_data); end
`endif
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        start_frame(8'hA5);
        for (int c = 1; c <= 30; c++) @(negedge clk);
        s_rst = 1'b1;
        @(negedge clk);
        s_rst = 1'b0;
        checks++; if (cs_n !== 1'b1 || sclk !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_pins: got cs_n=%b sclk=%b busy=%b expected 1/0/0", cs_n, sclk, busy); end
        checks++; if (done !== 1'b0 || mosi !== 1'b0) begin errors++; $display("[TB] FAIL abort_done_mosi: got done=%b mosi=%b expected 0/0", done, mosi); end
        monitor_frame(60, -1, -1, 1'b0);
        checks++; if (mon_done_cnt !== 0) begin errors++; $display("[TB] FAIL abort_no_done: got %0d expected 0", mon_done_cnt); end
        start_frame(8'h96);
        monitor_frame(80, -1, -1, 1'b0);
        checks++; if (mon_rises !== 8) begin errors++; $display("[TB] FAIL after_abort_rises: got %0d expected 8", mon_rises); end
        checks++; if (mon_bits !== 8'h96) begin errors++; $display("[TB] FAIL after_abort_bits: got %h expected 96", mon_bits); end
        checks++; if (mon_done_cyc !== 69) begin errors++; $display("[TB] FAIL after_abort_done: got %0d expected 69", mon_done_cyc); end
    endtask

    task automatic test_small_frame;
        int high_cnt = 0;
        int done_cyc = -1;
        int cs_fall = -1;
        logic bit_seen = 1'b0;
        @(negedge clk);
        s_tx    = 1'b1;
        s_start = 1'b1;
        @(posedge clk);
        #1;
        s_start = 1'b0;
        s_tx    = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (s_sclk) begin high_cnt++; bit_seen = s_mosi; end
            if (!s_cs_n && cs_fall < 0) cs_fall = c;
            if (s_done && done_cyc < 0) begin
                done_cyc = c;
`ifdef SPI_MISO_CAPTURE_EN
                checks++; if (s_rx_data !== 1'b1) begin errors++; $display("[TB] FAIL small_rx_data: got %b expected 1", s_rx_data); end
`endif
            end
        end
        checks++; if (high_cnt !== 1) begin errors++; $display("[TB] FAIL small_sclk_high: got %0d expected 1", high_cnt); end
        checks++; if (bit_seen !== 1'b1) begin errors++; $display("[TB] FAIL small_mosi: got %b expected 1", bit_seen); end
        checks++; if (cs_fall !== 1) begin errors++; $display("[TB] FAIL small_cs_fall: got %0d expected 1", cs_fall); end
        checks++; if (done_cyc !== 7) begin errors++; $display("[TB] FAIL small_done_cyc: got %0d expected 7", done_cyc); end
    endtask

`ifdef SPI_MISO_CAPTURE_EN
    task automatic test_miso_capture;
        start_frame(8'hC3);
        monitor_frame(80, -1, -1, 1'b1);
        checks++; if (rx_data !== 8'hC3) begin errors++; $display("[TB] FAIL miso_rx_data: got %h expected c3", rx_data); end
        checks++; if (mon_done_cyc !== 69) begin errors++; $display("[TB] FAIL miso_done_cyc: got %0d expected 69", mon_done_cyc); end
        repeat (4) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_small_frame();
`ifdef SPI_MISO_CAPTURE_EN
        test_miso_capture();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
